// File: rtl/id_ex_pipe_pkg.sv
// Shared codes and types for the ID->EX pipeline register.
// Holds the exop high-field unit-class codes, ALU select and memory-op encodings,
// and the NOP control payload presented by empty pipeline entries.
package id_ex_pipe_pkg;

  // Unit-class codes carried in the high field of exop. Any other value is a NOP.
  localparam int HI_CODE_W = 3;
  localparam logic [HI_CODE_W-1:0] HI_LOGIC = 3'd1;
  localparam logic [HI_CODE_W-1:0] HI_ARITH = 3'd2;
  localparam logic [HI_CODE_W-1:0] HI_SHIFT = 3'd3;
  localparam logic [HI_CODE_W-1:0] HI_MOVE  = 3'd4;

  localparam int ALU_SEL_W = 3;
  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_NOP   = 3'd0,
    ALU_LOGIC = 3'd1,
    ALU_ARITH = 3'd2,
    ALU_SHIFT = 3'd3,
    ALU_MOVE  = 3'd4
  } alu_sel_e;

  localparam int MEM_OP_W = 2;
  typedef enum logic [MEM_OP_W-1:0] {
    MEM_OP_NOP       = 2'd0,
    MEM_OP_WRITE_REG = 2'd1
  } mem_op_e;

  // Decoded control carried alongside the data in every pipeline entry.
  typedef struct packed {
    alu_sel_e alusel;
    mem_op_e  memop;
    logic     we;
  } ctrl_t;

  localparam ctrl_t NOP_CTRL = '{alusel: ALU_NOP, memop: MEM_OP_NOP, we: 1'b0};

endpackage

// File: rtl/id_ex_if.sv
// ID->EX handshake bundle: flush, ID-side offer (valid/ready + payload) and EX-side
// entry (valid/ready + decoded payload).
// Modports: slave = the pipeline register, master = the surrounding ID/EX/control logic.
interface id_ex_if #(
  parameter int WORD_W     = 32,
  parameter int IMM_W      = 16,
  parameter int REG_ADDR_W = 5,
  parameter int EXOP_HI_W  = 3,
  parameter int EXOP_LO_W  = 5
);
  import id_ex_pipe_pkg::*;

  logic                           flush;

  logic                           id_valid;
  logic                           id_ready;
  logic [EXOP_HI_W+EXOP_LO_W-1:0] id_exop;
  logic [WORD_W-1:0]              id_srcl;
  logic [WORD_W-1:0]              id_srcr;
  logic [IMM_W-1:0]               id_offset;
  logic [REG_ADDR_W-1:0]          id_dest;

  logic                           ex_valid;
  logic                           ex_ready;
  logic [ALU_SEL_W-1:0]           ex_alusel;
  logic [EXOP_LO_W-1:0]           ex_aluop;
  logic [WORD_W-1:0]              ex_srcl;
  logic [WORD_W-1:0]              ex_srcr;
  logic [IMM_W-1:0]               ex_offset;
  logic [MEM_OP_W-1:0]            ex_memop;
  logic [REG_ADDR_W-1:0]          ex_dest;
  logic                           ex_write_enable;

  modport slave (
    input  flush, id_valid, id_exop, id_srcl, id_srcr, id_offset, id_dest, ex_ready,
    output id_ready, ex_valid, ex_alusel, ex_aluop, ex_srcl, ex_srcr, ex_offset,
           ex_memop, ex_dest, ex_write_enable
  );

  modport master (
    output flush, id_valid, id_exop, id_srcl, id_srcr, id_offset, id_dest, ex_ready,
    input  id_ready, ex_valid, ex_alusel, ex_aluop, ex_srcl, ex_srcr, ex_offset,
           ex_memop, ex_dest, ex_write_enable
  );

endinterface

// File: rtl/id_ex_pipe_decode.sv
// id_ex_decode: combinational exop high-field -> {alusel, memop, we}.
// Ports: hi (exop unit-class field), dest (destination register), ctrl (decoded control).
// A write to register 0 is suppressed: we=0 and memop=NOP whatever the unit class.
module id_ex_decode
  import id_ex_pipe_pkg::*;
#(
  parameter int HI_W       = 3,
  parameter int REG_ADDR_W = 5
) (
  input  logic [HI_W-1:0]       hi,
  input  logic [REG_ADDR_W-1:0] dest,
  output ctrl_t                 ctrl
);

  localparam logic [HI_W-1:0] C_LOGIC = HI_W'(HI_LOGIC);
  localparam logic [HI_W-1:0] C_ARITH = HI_W'(HI_ARITH);
  localparam logic [HI_W-1:0] C_SHIFT = HI_W'(HI_SHIFT);
  localparam logic [HI_W-1:0] C_MOVE  = HI_W'(HI_MOVE);

  always_comb begin
    ctrl = NOP_CTRL;
    case (hi)
      C_LOGIC: ctrl = '{alusel: ALU_LOGIC, memop: MEM_OP_WRITE_REG, we: 1'b1};
      C_ARITH: ctrl = '{alusel: ALU_ARITH, memop: MEM_OP_WRITE_REG, we: 1'b1};
      C_SHIFT: ctrl = '{alusel: ALU_SHIFT, memop: MEM_OP_WRITE_REG, we: 1'b1};
      C_MOVE:  ctrl = '{alusel: ALU_MOVE,  memop: MEM_OP_WRITE_REG, we: 1'b1};
      default: ctrl = NOP_CTRL;
    endcase
    if (dest == '0) begin
      ctrl.we    = 1'b0;
      ctrl.memop = MEM_OP_NOP;
    end
  end

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID->EX pipeline register with valid/ready handshake, stall, flush and
// registered decode of the exop high field. Ports: clk, rst (async, active-high), bus
// (id_ex_if.slave). Optional ID_EX_SKID_EN macro adds a one-entry skid, registered id_ready.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int IMM_W      = 16,
  parameter int REG_ADDR_W = 5,
  parameter int EXOP_HI_W  = 3,
  parameter int EXOP_LO_W  = 5
) (
  input  logic    clk,
  input  logic    rst,
  id_ex_if.slave  bus
);

  typedef struct packed {
    ctrl_t                 ctrl;
    logic [EXOP_LO_W-1:0]  aluop;
    logic [WORD_W-1:0]     srcl;
    logic [WORD_W-1:0]     srcr;
    logic [IMM_W-1:0]      offset;
    logic [REG_ADDR_W-1:0] dest;
  } entry_t;

  localparam entry_t NOP_ENTRY = '{ctrl: NOP_CTRL, aluop: '0, srcl: '0, srcr: '0,
                                   offset: '0, dest: '0};

  ctrl_t  dec_ctrl;
  entry_t in_entry;
  entry_t out_q;
  logic   out_vld;
  logic   id_ready;
  logic   accept;
  logic   drain;

  // Decode happens on the way in so the registered entry already carries its control.
  id_ex_decode #(
    .HI_W       (EXOP_HI_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_decode (
    .hi   (bus.id_exop[EXOP_HI_W+EXOP_LO_W-1 -: EXOP_HI_W]),
    .dest (bus.id_dest),
    .ctrl (dec_ctrl)
  );

  assign in_entry = '{ctrl:   dec_ctrl,
                      aluop:  bus.id_exop[EXOP_LO_W-1:0],
                      srcl:   bus.id_srcl,
                      srcr:   bus.id_srcr,
                      offset: bus.id_offset,
                      dest:   bus.id_dest};

  // The output slot can take a new value this edge when empty or being consumed.
  assign drain  = !out_vld || bus.ex_ready;
  assign accept = bus.id_valid && id_ready;

`ifdef ID_EX_SKID_EN
  entry_t skid_q;
  logic   skid_vld;
  logic   rdy_q;

  // rdy_q mirrors !skid_vld for the next cycle; it is low exactly when the skid is full,
  // so an accept never coincides with a skid-to-output move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_q    <= NOP_ENTRY;
      skid_vld <= 1'b0;
      skid_q   <= NOP_ENTRY;
      rdy_q    <= 1'b0;
    end else if (bus.flush) begin
      out_vld  <= 1'b0;
      out_q    <= NOP_ENTRY;
      skid_vld <= 1'b0;
      skid_q   <= NOP_ENTRY;
      rdy_q    <= 1'b1;
    end else if (drain) begin
      if (skid_vld) begin
        out_vld  <= 1'b1;
        out_q    <= skid_q;
        skid_vld <= 1'b0;
        skid_q   <= NOP_ENTRY;
      end else if (accept) begin
        out_vld <= 1'b1;
        out_q   <= in_entry;
      end else begin
        out_vld <= 1'b0;
        out_q   <= NOP_ENTRY;
      end
      rdy_q <= 1'b1;
    end else begin
      // Output held: a new accept parks in the skid.
      if (accept) begin
        skid_vld <= 1'b1;
        skid_q   <= in_entry;
        rdy_q    <= 1'b0;
      end else begin
        rdy_q <= !skid_vld;
      end
    end
  end

  assign id_ready = rdy_q;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_q   <= NOP_ENTRY;
    end else if (bus.flush) begin
      out_vld <= 1'b0;
      out_q   <= NOP_ENTRY;
    end else if (drain) begin
      out_vld <= accept;
      out_q   <= accept ? in_entry : NOP_ENTRY;
    end
  end

  // Gated by rst so ID sees not-ready for the whole reset window.
  assign id_ready = drain && !rst;
`endif

  assign bus.id_ready        = id_ready;
  assign bus.ex_valid        = out_vld;
  assign bus.ex_alusel       = out_q.ctrl.alusel;
  assign bus.ex_memop        = out_q.ctrl.memop;
  assign bus.ex_write_enable = out_q.ctrl.we;
  assign bus.ex_aluop        = out_q.aluop;
  assign bus.ex_srcl         = out_q.srcl;
  assign bus.ex_srcr         = out_q.srcr;
  assign bus.ex_offset       = out_q.offset;
  assign bus.ex_dest         = out_q.dest;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed steps plus randomized traffic, compared
// each cycle against a queue-based reference of in-flight instructions.
module tb_id_ex_pipe;
  import id_ex_pipe_pkg::*;

  typedef struct packed {
    logic [2:0]  alusel;
    logic [4:0]  aluop;
    logic [31:0] srcl;
    logic [31:0] srcr;
    logic [15:0] offset;
    logic [1:0]  memop;
    logic [4:0]  dest;
    logic        we;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  exp_t q[$];
  bit   seen_edge;

  id_ex_if bus ();

  id_ex_pipe dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Architectural decode table: unit classes write a register, everything else is a NOP;
  // register 0 is never written.
  function automatic exp_t ref_decode(input logic [7:0] exop, input logic [31:0] sl,
                                      input logic [31:0] sr, input logic [15:0] off,
                                      input logic [4:0] d);
    exp_t e;
    e.aluop = exop[4:0]; e.srcl = sl; e.srcr = sr; e.offset = off; e.dest = d;
    if      (exop[7:5] == HI_LOGIC) e.alusel = ALU_LOGIC;
    else if (exop[7:5] == HI_ARITH) e.alusel = ALU_ARITH;
    else if (exop[7:5] == HI_SHIFT) e.alusel = ALU_SHIFT;
    else if (exop[7:5] == HI_MOVE)  e.alusel = ALU_MOVE;
    else                            e.alusel = ALU_NOP;
    e.we    = (e.alusel != ALU_NOP) && (d != 5'd0);
    e.memop = e.we ? MEM_OP_WRITE_REG : MEM_OP_NOP;
    return e;
  endfunction

  // Capacity is one entry without skid (ready when empty or draining), two with skid
  // (ready registered, so low until the first edge after reset).
  function automatic bit exp_rdy();
`ifdef ID_EX_SKID_EN
    return seen_edge && (q.size() < 2);
`else
    return (q.size() == 0) || (bus.ex_ready == 1'b1);
`endif
  endfunction

  task automatic check_out();
    exp_t e;
    e = '0;
    if (q.size() > 0) e = q[0];
    check("ex_valid",        bus.ex_valid, q.size() > 0);
    check("ex_alusel",       bus.ex_alusel, e.alusel);
    check("ex_aluop",        bus.ex_aluop, e.aluop);
    check("ex_srcl",         bus.ex_srcl, e.srcl);
    check("ex_srcr",         bus.ex_srcr, e.srcr);
    check("ex_offset",       bus.ex_offset, e.offset);
    check("ex_memop",        bus.ex_memop, e.memop);
    check("ex_dest",         bus.ex_dest, e.dest);
    check("ex_write_enable", bus.ex_write_enable, e.we);
  endtask

  // One clock: drive inputs, check ready, advance the reference at the edge, check outputs.
  task automatic step(input bit v, input logic [7:0] exop, input logic [31:0] sl,
                      input logic [31:0] sr, input logic [15:0] off, input logic [4:0] d,
                      input bit er, input bit fl, output bit took);
    bit pop;
    bus.id_valid = v; bus.id_exop = exop; bus.id_srcl = sl; bus.id_srcr = sr;
    bus.id_offset = off; bus.id_dest = d; bus.ex_ready = er; bus.flush = fl;
    #1;
    check("id_ready", bus.id_ready, exp_rdy());
    took = v && exp_rdy() && !fl;
    pop  = (q.size() > 0) && er;
    @(posedge clk);
    seen_edge = 1'b1;
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (took) q.push_back(ref_decode(exop, sl, sr, off, d));
    end
    @(negedge clk);
    check_out();
  endtask

  task automatic idle(input bit er);
    bit t;
    step(1'b0, 8'h00, 32'h0, 32'h0, 16'h0, 5'd0, er, 1'b0, t);
  endtask

  initial begin
    bit took;
    bit b_taken;
    logic [31:0] a_srcl;
    n_cmp = 0; n_err = 0; seen_edge = 1'b0;
    rst = 1'b1;
    bus.flush = 1'b0; bus.id_valid = 1'b0; bus.id_exop = '0; bus.id_srcl = '0;
    bus.id_srcr = '0; bus.id_offset = '0; bus.id_dest = '0; bus.ex_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst id_ready", bus.id_ready, 1'b0);
    check_out();
    rst = 1'b0;
    idle(1'b1);

    // Basic LOGIC instruction, one-cycle latency
    step(1'b1, {HI_LOGIC, 5'h03}, 32'h0000_00F0, 32'h1234_5678, 16'h00AA, 5'd4, 1'b1, 1'b0, took);
    check("t1 ex_valid", bus.ex_valid, 1'b1);
    check("t1 alusel",   bus.ex_alusel, ALU_LOGIC);
    check("t1 aluop",    bus.ex_aluop, 5'h03);
    check("t1 memop",    bus.ex_memop, MEM_OP_WRITE_REG);
    check("t1 we",       bus.ex_write_enable, 1'b1);
    check("t1 srcl",     bus.ex_srcl, 32'h0000_00F0);

    // Unknown high field, then a register-0 destination
    step(1'b1, {3'b111, 5'h01}, 32'h11, 32'h22, 16'h33, 5'd7, 1'b1, 1'b0, took);
    check("t2 alusel", bus.ex_alusel, ALU_NOP);
    check("t2 memop",  bus.ex_memop, MEM_OP_NOP);
    check("t2 we",     bus.ex_write_enable, 1'b0);
    check("t2 valid",  bus.ex_valid, 1'b1);
    step(1'b1, {HI_ARITH, 5'h02}, 32'h44, 32'h55, 16'h66, 5'd0, 1'b1, 1'b0, took);
    check("t3 we",    bus.ex_write_enable, 1'b0);
    check("t3 memop", bus.ex_memop, MEM_OP_NOP);
    idle(1'b1);

    // Stall: A held, B offered for three cycles, then drain in order
    a_srcl = 32'hAAAA_0001;
    step(1'b1, {HI_SHIFT, 5'h04}, a_srcl, 32'h1, 16'h1, 5'd9, 1'b0, 1'b0, took);
    b_taken = 1'b0;
    repeat (3) begin
      step(!b_taken, {HI_MOVE, 5'h05}, 32'hBBBB_0002, 32'h2, 16'h2, 5'd10, 1'b0, 1'b0, took);
      b_taken |= took;
      check("stall A held", bus.ex_srcl, a_srcl);
    end
    repeat (4) begin
      step(!b_taken, {HI_MOVE, 5'h05}, 32'hBBBB_0002, 32'h2, 16'h2, 5'd10, 1'b1, 1'b0, took);
      b_taken |= took;
    end
    check("stall drained", bus.ex_valid, 1'b0);

    // Flush with entries held and an instruction offered
    step(1'b1, {HI_ARITH, 5'h06}, 32'hC0, 32'hC1, 16'hC2, 5'd3, 1'b0, 1'b0, took);
    step(1'b1, {HI_LOGIC, 5'h07}, 32'hD0, 32'hD1, 16'hD2, 5'd5, 1'b0, 1'b0, took);
    step(1'b1, {HI_MOVE, 5'h08}, 32'hE0, 32'hE1, 16'hE2, 5'd6, 1'b0, 1'b1, took);
    check("flush ex_valid", bus.ex_valid, 1'b0);
    check("flush srcl",     bus.ex_srcl, 32'h0);
    check("flush id_ready", bus.id_ready, 1'b1);
    idle(1'b1);
    check("flush no ghost", bus.ex_valid, 1'b0);

    // Asynchronous reset pulse mid-stall, between edges
    step(1'b1, {HI_ARITH, 5'h09}, 32'hF0, 32'hF1, 16'hF2, 5'd8, 1'b0, 1'b0, took);
    step(1'b1, {HI_LOGIC, 5'h0A}, 32'hF3, 32'hF4, 16'hF5, 5'd9, 1'b0, 1'b0, took);
    bus.id_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    q.delete();
    seen_edge = 1'b0;
    check("arst id_ready", bus.id_ready, 1'b0);
    check_out();
    @(negedge clk);
    rst = 1'b0;
    idle(1'b1);
    step(1'b1, {HI_MOVE, 5'h0B}, 32'h5EED_0001, 32'h2, 16'h3, 5'd12, 1'b1, 1'b0, took);
    check("restart srcl",  bus.ex_srcl, 32'h5EED_0001);
    check("restart valid", bus.ex_valid, 1'b1);

    // Randomized traffic with intermittent stalls and flushes
    for (int i = 0; i < 600; i++) begin
      logic [4:0] d;
      d = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom, $urandom, 16'($urandom), d,
           $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, took);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
